// File: rtl/correlator_packet_framer.sv
// Correlator readout packet framer: snapshots header/payload/timestamp and streams them MSB-first as ASCII hex or raw bytes, ending with 0x0D.
// Optional CRC-16/CCITT trailer is compiled in when PACKET_CRC_EN is defined.
module correlator_packet_framer #(
    parameter int NUM_WORDS  = 16,
    parameter int RESOLUTION = 24,
    parameter int BINARY     = 0,
    parameter int DROP_W     = 8
) (
    input  logic                            intclk,
    input  logic                            reset,
    input  logic                            capture,
    input  logic [63:0]                     header,
    input  logic [NUM_WORDS*RESOLUTION-1:0] payload,
    input  logic [63:0]                     timestamp,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            busy,
    output logic [DROP_W-1:0]               dropped
);

    localparam int PAY_BITS  = NUM_WORDS * RESOLUTION;
    localparam int PAY_BYTES = (PAY_BITS + 7) / 8;
    localparam int B         = 16 + PAY_BYTES;
    localparam int FRAME_W   = 8 * B;
`ifdef PACKET_CRC_EN
    localparam int TX_BYTES  = B + 2;
`else
    localparam int TX_BYTES  = B;
`endif
    localparam int N_CHARS   = (BINARY != 0) ? TX_BYTES : 2 * TX_BYTES;
    localparam int IDX_W     = $clog2(2 * TX_BYTES + 2);
    localparam logic [IDX_W-1:0] LAST_CHAR = IDX_W'(N_CHARS - 1);
`ifdef PACKET_CRC_EN
    localparam logic [IDX_W-1:0] LAST_FRAME_CHAR = IDX_W'((BINARY != 0) ? B - 1 : 2 * B - 1);
`endif

    typedef enum logic [1:0] {IDLE, LOAD, SEND, TERM} state_t;

    state_t                 state_q, state_d;
    logic                   cap_q, cap_prev_q;
    logic [FRAME_W-1:0]     frame_q, frame_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DROP_W-1:0]      dropped_q, dropped_d;
`ifdef PACKET_CRC_EN
    logic [15:0]            crc_q, crc_d;
`endif

    logic [8*PAY_BYTES-1:0] pay_ext;
    logic                   cap_edge;
    logic                   accept;
    logic                   byte_done;
    logic [7:0]             top_byte;
    logic [3:0]             nib;
    logic [7:0]             send_char;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

`ifdef PACKET_CRC_EN
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c ^ {d, 8'h00};
        for (int i = 0; i < 8; i++) begin
            r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction
`endif

    always_comb begin
        pay_ext = '0;
        pay_ext[PAY_BITS-1:0] = payload;
    end

    // Two-stage capture history so the request edge is registered before the snapshot.
    assign cap_edge  = cap_q & ~cap_prev_q;
    assign tx_valid  = (state_q == SEND) || (state_q == TERM);
    assign busy      = (state_q != IDLE);
    assign dropped   = dropped_q;
    assign accept    = tx_valid & tx_ready;
    assign top_byte  = frame_q[FRAME_W-1 -: 8];
    assign byte_done = accept && (state_q == SEND) && ((BINARY != 0) || idx_q[0]);
    assign nib       = idx_q[0] ? top_byte[3:0] : top_byte[7:4];
    assign send_char = (BINARY != 0) ? top_byte : hex_char(nib);

    always_comb begin
        tx_data = 8'h00;
        if (state_q == SEND) begin
            tx_data = send_char;
        end else if (state_q == TERM) begin
            tx_data = 8'h0D;
        end
    end

    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        idx_d     = idx_q;
        dropped_d = dropped_q;
`ifdef PACKET_CRC_EN
        crc_d     = crc_q;
`endif
        if (cap_edge && (state_q != IDLE) && (dropped_q != {DROP_W{1'b1}})) begin
            dropped_d = dropped_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (cap_edge) begin
                    frame_d = {header, pay_ext, timestamp};
                    idx_d   = '0;
`ifdef PACKET_CRC_EN
                    crc_d   = 16'hFFFF;
`endif
                    state_d = LOAD;
                end
            end
            LOAD: state_d = SEND;
            SEND: begin
                if (accept) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LAST_CHAR) begin
                        state_d = TERM;
                    end
                end
                if (byte_done) begin
                    frame_d = {frame_q[FRAME_W-9:0], 8'h00};
`ifdef PACKET_CRC_EN
                    // The CRC is folded in as bytes leave, then parked at the top of the shifter behind the timestamp.
                    if (idx_q <= LAST_FRAME_CHAR) begin
                        crc_d = crc_step(crc_q, top_byte);
                    end
                    if (idx_q == LAST_FRAME_CHAR) begin
                        frame_d[FRAME_W-1 -: 16] = crc_step(crc_q, top_byte);
                    end
`endif
                end
            end
            TERM: begin
                if (accept) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge intclk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cap_q      <= 1'b0;
            cap_prev_q <= 1'b0;
            frame_q    <= '0;
            idx_q      <= '0;
            dropped_q  <= '0;
`ifdef PACKET_CRC_EN
            crc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cap_q      <= capture;
            cap_prev_q <= cap_q;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            dropped_q  <= dropped_d;
`ifdef PACKET_CRC_EN
            crc_q      <= crc_d;
`endif
        end
    end

endmodule

// File: tb/tb_correlator_packet_framer.sv
// Scoreboard bench for correlator_packet_framer: one ASCII instance (8-bit payload) and one binary instance (12-bit payload).
module tb_correlator_packet_framer;

    logic        intclk = 1'b0;
    logic        reset;
    logic        capture;
    logic [63:0] hdr;
    logic [7:0]  pay_a;
    logic [11:0] pay_b;
    logic [63:0] ts;
    logic [7:0]  data_a, data_b;
    logic        vld_a, vld_b;
    logic        rdy_a = 1'b1;
    logic        rdy_b;
    logic        busy_a, busy_b;
    logic [1:0]  drop_a, drop_b;
    logic        bp_en = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    string hexs = "0123456789ABCDEF";

`ifdef PACKET_CRC_EN
    localparam int XFER_A = 39;
    localparam int XFER_B = 21;
`else
    localparam int XFER_A = 35;
    localparam int XFER_B = 19;
`endif

    always #5 intclk = ~intclk;

    correlator_packet_framer #(.NUM_WORDS(1), .RESOLUTION(8), .BINARY(0), .DROP_W(2)) u_asc (
        .intclk(intclk), .reset(reset), .capture(capture), .header(hdr), .payload(pay_a),
        .timestamp(ts), .tx_data(data_a), .tx_valid(vld_a), .tx_ready(rdy_a),
        .busy(busy_a), .dropped(drop_a));

    correlator_packet_framer #(.NUM_WORDS(1), .RESOLUTION(12), .BINARY(1), .DROP_W(2)) u_bin (
        .intclk(intclk), .reset(reset), .capture(capture), .header(hdr), .payload(pay_b),
        .timestamp(ts), .tx_data(data_b), .tx_valid(vld_b), .tx_ready(rdy_b),
        .busy(busy_b), .dropped(drop_b));

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

`ifdef PACKET_CRC_EN
    function automatic logic [15:0] crc_bits(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction
`endif

    task automatic push_pkt(input logic [63:0] h, input logic [7:0] pa, input logic [11:0] pb, input logic [63:0] t);
        logic [135:0] fa;
        logic [143:0] fb;
        logic [7:0]   by;
`ifdef PACKET_CRC_EN
        logic [15:0]  ca, cb;
        ca = 16'hFFFF;
        cb = 16'hFFFF;
`endif
        fa = {h, pa, t};
        fb = {h, 4'h0, pb, t};
        for (int i = 0; i < 17; i++) begin
            by = fa[135-8*i -: 8];
            exp_a.push_back(hexs[by[7:4]]);
            exp_a.push_back(hexs[by[3:0]]);
`ifdef PACKET_CRC_EN
            ca = crc_bits(ca, by);
`endif
        end
        for (int i = 0; i < 18; i++) begin
            by = fb[143-8*i -: 8];
            exp_b.push_back(by);
`ifdef PACKET_CRC_EN
            cb = crc_bits(cb, by);
`endif
        end
`ifdef PACKET_CRC_EN
        exp_a.push_back(hexs[ca[15:12]]);
        exp_a.push_back(hexs[ca[11:8]]);
        exp_a.push_back(hexs[ca[7:4]]);
        exp_a.push_back(hexs[ca[3:0]]);
        exp_b.push_back(cb[15:8]);
        exp_b.push_back(cb[7:0]);
`endif
        exp_a.push_back(8'h0D);
        exp_b.push_back(8'h0D);
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((busy_a || busy_b) && c < 2000) begin
            @(negedge intclk);
            c++;
        end
        chk("idle_timeout", {62'd0, busy_a, busy_b}, 64'd0);
    endtask

    task automatic launch(input logic [63:0] h, input logic [7:0] pa, input logic [11:0] pb, input logic [63:0] t);
        hdr = h; pay_a = pa; pay_b = pb; ts = t;
        push_pkt(h, pa, pb, t);
        @(negedge intclk);
        capture = 1'b1;
        repeat (3) @(negedge intclk);
        capture = 1'b0;
    endtask

    always @(posedge intclk) begin
        #1;
        rdy_a = bp_en ? ($urandom_range(0, 99) >= 30) : 1'b1;
    end

    logic       hold_a = 1'b0, hold_b = 1'b0;
    logic [7:0] last_a = 8'h00, last_b = 8'h00;

    // Monitor A: pops the ASCII scoreboard on every handshake and checks hold-while-stalled.
    always @(negedge intclk) begin
        if (!reset) begin
            hold_a = 1'b0;
        end else begin
            if (hold_a) begin
                chk("a_hold_valid", {63'd0, vld_a}, 64'd1);
                chk("a_hold_data", {56'd0, data_a}, {56'd0, last_a});
            end
            if (vld_a && rdy_a) begin
                if (exp_a.size() == 0) begin
                    chk("a_unexpected", {56'd0, data_a}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("a_data", {56'd0, data_a}, {56'd0, exp_a.pop_front()});
                end
            end
            hold_a = vld_a && !rdy_a;
            last_a = data_a;
        end
    end

    // Monitor B: same for the binary instance.
    always @(negedge intclk) begin
        if (!reset) begin
            hold_b = 1'b0;
        end else begin
            if (hold_b) begin
                chk("b_hold_valid", {63'd0, vld_b}, 64'd1);
                chk("b_hold_data", {56'd0, data_b}, {56'd0, last_b});
            end
            if (vld_b && rdy_b) begin
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", {56'd0, data_b}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    chk("b_data", {56'd0, data_b}, {56'd0, exp_b.pop_front()});
                end
            end
            hold_b = vld_b && !rdy_b;
            last_b = data_b;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int na, nb, ba, bb, guard;
        reset = 1'b0; capture = 1'b0; rdy_b = 1'b1;
        hdr = '0; pay_a = '0; pay_b = '0; ts = '0;
        repeat (3) @(negedge intclk);
        chk("rst_vld_a", {63'd0, vld_a}, 64'd0);
        chk("rst_busy_a", {63'd0, busy_a}, 64'd0);
        chk("rst_data_a", {56'd0, data_a}, 64'd0);
        chk("rst_drop_a", {62'd0, drop_a}, 64'd0);
        chk("rst_vld_b", {63'd0, vld_b}, 64'd0);
        chk("rst_busy_b", {63'd0, busy_b}, 64'd0);
        reset = 1'b1;
        repeat (2) @(negedge intclk);

        // T2/T3: nominal packet, latency and back-to-back transfers
        hdr = 64'h0123456789ABCDEF; pay_a = 8'hA5; pay_b = 12'hABC; ts = 64'h0;
        push_pkt(hdr, pay_a, pay_b, ts);
        capture = 1'b1;
        @(negedge intclk);
        chk("lat_n_busy_a", {63'd0, busy_a}, 64'd0);
        chk("lat_n_busy_b", {63'd0, busy_b}, 64'd0);
        @(negedge intclk);
        chk("lat_n1_busy_a", {63'd0, busy_a}, 64'd1);
        chk("lat_n1_vld_a", {63'd0, vld_a}, 64'd0);
        chk("lat_n1_busy_b", {63'd0, busy_b}, 64'd1);
        chk("lat_n1_vld_b", {63'd0, vld_b}, 64'd0);
        @(negedge intclk);
        chk("lat_n2_vld_a", {63'd0, vld_a}, 64'd1);
        chk("lat_n2_vld_b", {63'd0, vld_b}, 64'd1);
        capture = 1'b0;
        na = 0; nb = 0; ba = 0; bb = 0; guard = 0;
        while ((busy_a || busy_b) && guard < 200) begin
            if (busy_a) begin na++; if (!vld_a) ba++; end
            if (busy_b) begin nb++; if (!vld_b) bb++; end
            guard++;
            @(negedge intclk);
        end
        chk("xfer_cnt_a", na, XFER_A);
        chk("bubbles_a", ba, 0);
        chk("xfer_cnt_b", nb, XFER_B);
        chk("bubbles_b", bb, 0);
        chk("drop_after_t2_a", {62'd0, drop_a}, 64'd0);
        chk("drop_after_t2_b", {62'd0, drop_b}, 64'd0);

        // T4: random backpressure on the ASCII stream
        bp_en = 1'b1;
        launch(64'h0123456789ABCDEF, 8'hA5, 12'hABC, 64'h0);
        wait_idle();
        bp_en = 1'b0;
        repeat (3) @(negedge intclk);

        // T5: captures while busy, saturating drop counter, inputs changed in flight
        hdr = 64'hFEDCBA9876543210; pay_a = 8'h3C; pay_b = 12'h5F0; ts = 64'h0011223344556677;
        push_pkt(hdr, pay_a, pay_b, ts);
        capture = 1'b1;
        repeat (3) @(negedge intclk);
        hdr = 64'hDEADBEEFDEADBEEF; pay_a = 8'hFF; pay_b = 12'hFFF; ts = 64'hFFFFFFFFFFFFFFFF;
        for (int k = 1; k <= 4; k++) begin
            capture = 1'b0;
            @(negedge intclk);
            capture = 1'b1;
            repeat (2) @(negedge intclk);
            chk("drop_cnt_a", {62'd0, drop_a}, (k > 3) ? 64'd3 : 64'(k));
            chk("drop_cnt_b", {62'd0, drop_b}, (k > 3) ? 64'd3 : 64'(k));
        end
        capture = 1'b0;
        wait_idle();
        repeat (3) @(negedge intclk);
        chk("drop_hold_a", {62'd0, drop_a}, 64'd3);

        // T1: reset in the middle of SEND
        launch(64'h1122334455667788, 8'h5A, 12'h123, 64'h8877665544332211);
        repeat (6) @(negedge intclk);
        @(posedge intclk);
        #2;
        reset = 1'b0;
        exp_a.delete();
        exp_b.delete();
        @(negedge intclk);
        chk("midrst_vld_a", {63'd0, vld_a}, 64'd0);
        chk("midrst_busy_a", {63'd0, busy_a}, 64'd0);
        chk("midrst_drop_a", {62'd0, drop_a}, 64'd0);
        chk("midrst_vld_b", {63'd0, vld_b}, 64'd0);
        chk("midrst_busy_b", {63'd0, busy_b}, 64'd0);
        chk("midrst_drop_b", {62'd0, drop_b}, 64'd0);
        @(posedge intclk);
        #2;
        reset = 1'b1;
        repeat (10) @(negedge intclk);
        chk("post_rst_quiet_a", {62'd0, vld_a, busy_a}, 64'd0);
        chk("post_rst_quiet_b", {62'd0, vld_b, busy_b}, 64'd0);

        // Recovery packet after reset
        launch(64'hA5A5A5A55A5A5A5A, 8'h00, 12'h00F, 64'h0102030405060708);
        wait_idle();
        repeat (3) @(negedge intclk);
        chk("pending_a", exp_a.size(), 0);
        chk("pending_b", exp_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
